gps_sat_channel: RTL and testbench
==================================

Name: gps_sat_channel

Overview:
Next-generation single-satellite signal generator for the GPS emulator. It is instantiated Nsat times and summed downstream.
Adds behaviour the previous generator lacked: a parametrised output width, a code-Doppler NCO, PRN 1-37 (including SV37), 50 bps nav-data modulation with a ready/valid handshake, and atomic configuration load.
Outputs signed baseband I/Q for one satellite at the sample clock.

Parameters:
PHASE_W, 32, width of the carrier and code NCO accumulators and their increments.
GAIN_W, 15, unsigned gain width; I/Q outputs are GAIN_W+1 bits signed.

Ports:
clk  in  1  sample clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset.
enable  in  1  advance NCOs/counters when high; hold state when low.
cfg_load  in  1  one-cycle pulse; latches freq/code_rate/gain/ca_sel and restarts the code epoch.
freq  in  PHASE_W  carrier Doppler phase increment, two's complement, modulo 2^PHASE_W.
code_rate  in  PHASE_W  unsigned code-NCO increment; each carry out advances one chip.
gain  in  GAIN_W  unsigned amplitude.
ca_sel  in  6  PRN select; 0-36 selects SV 1-37.
data_valid  in  1  nav bit offered.
data_bit  in  1  nav bit value.
data_ready  out  1  staging register can accept a bit.
i_out  out  GAIN_W+1  signed in-phase sample.
q_out  out  GAIN_W+1  signed quadrature sample.
epoch  out  1  one-cycle pulse on code wrap, chip 1022 to 0.
bit_edge  out  1  one-cycle pulse on the 20th epoch (nav bit boundary).
underrun  out  1  sticky; a bit boundary occurred with the staging register empty.
cfg_err  out  1  active ca_sel is greater than 36.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All accumulators and counters are 0; active config registers are 0.
  - G1 and G2 are loaded with all ones; staging is empty; active data bit is 0.
  - i_out=q_out=0; epoch=bit_edge=underrun=cfg_err=0; data_ready=0.
  - data_ready reaches 1 in the first cycle after release.
- Config:
  - cfg_load copies the inputs into the active registers.
  - It also zeroes carr_phase, code_phase, chip_cnt (0-1022) and ms_cnt (0-19), reloads G1/G2 to all ones, empties staging and clears underrun.
  - The active data bit is set to 0.
  - cfg_load takes priority over every other event in the same cycle, whether enable is high or low.
- cfg_err is registered as (active ca_sel > 36). While it is set, i_out=q_out=0 and the counters still run.
- Code generation:
  - The G1/G2 10-stage LFSRs follow IS-GPS-200: G1 = 1+x^3+x^10; G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10.
  - The chip is G1[10] XOR (XOR of the G2 tap pair for the PRN). PRN 37 uses the same taps as PRN 34.
- Per enabled cycle:
  - {carry, code_phase} = code_phase + code_rate. The carry steps the LFSRs and chip_cnt.
  - When chip_cnt wraps 1022 to 0: G1/G2 are reloaded to all ones, epoch pulses, and ms_cnt increments.
  - When ms_cnt wraps 19 to 0: bit_edge pulses (same cycle as that epoch).
  - carr_phase += freq, modulo 2^PHASE_W.
- Nav data handshake:
  - data_ready = !staging_full && !cfg_load. A transfer occurs when data_valid && data_ready.
  - At bit_edge with staging full: active bit = staging, and staging empties. A transfer in the same cycle is accepted (it refills staging).
  - At bit_edge with staging empty: the active bit becomes 0 and underrun sets.
- Carrier, 1-bit quadrature, with m = the top 2 bits of carr_phase:
  - cos_sign is negative when m[1]^m[0] = 1.
  - sin_sign is negative when m[1] = 1.
- Symbol: s = +1 when chip XOR active bit = 0, else -1.
- Outputs:
  - i_out = s*cos_sign*gain; q_out = s*sin_sign*gain.
  - The maximum magnitude 2^GAIN_W-1 always fits, so no saturation is needed.
  - Registered, latency 1 cycle from the state that produced them.
- enable low: all state holds, i_out=q_out=0, epoch=bit_edge=0, and the handshake still operates.
- Reset asserted mid-operation overrides everything in that cycle.

Test Plan:
- Chip sequence: rst_n 0→1, ca_sel=0, code_rate=2^31, freq=0, gain=1000, cfg_load, enable=1.
  → i_out follows PRN1, first 10 chips 1100100000 (octal 1440), 2 cycles per chip: -1000,-1000,-1000,-1000,+1000,… and q_out=i_out.
  → epoch every 2046 cycles; bit_edge every 40920 cycles.
- Carrier: freq=2^30, code_rate=0, gain=5. → (i,q) cycles through (+5,+5), (-5,+5), (-5,-5), (+5,-5) with period 4 cycles.
- Nav data: supply data_bit=1 before the first bit_edge. → from the cycle after bit_edge, the output sign is inverted relative to the chip, and data_ready returns to 1.
  → Withhold the next bit → underrun=1 at the next bit_edge and the data bit becomes 0.
- Simultaneous events: cfg_load in the same cycle as bit_edge and data_valid.
  → Counters restart at 0, staging is empty, underrun=0, and the offered bit is not accepted (data_ready=0 that cycle).
- PRN 37 / error: ca_sel=36 → chips equal those of ca_sel=33.
  → ca_sel=40 → cfg_err=1 and i_out=q_out=0, while epoch still pulses every 2046 cycles.
- enable / reset: drop enable for 100 cycles mid-epoch → outputs 0 and the chip sequence resumes without loss.
  → Assert rst_n=0 for 1 cycle mid-bit → all outputs 0 the next cycle, and data_ready=0 then 1.

Source files
------------

// File: rtl/gps_sat_channel_if.sv
// Nav-data handshake between the nav-message source and one satellite channel.
interface gps_sat_channel_if;
    // Valid/ready: a bit transfers on a rising clk edge where data_valid && data_ready.
    // The source keeps data_bit stable while data_valid is high, and data_ready never
    // depends on data_valid, so the two sides cannot form a combinational loop.
    logic data_valid;
    logic data_bit;
    logic data_ready;

    modport master (output data_valid, output data_bit, input data_ready);
    modport slave  (input data_valid, input data_bit, output data_ready);
endinterface

// File: rtl/gps_sat_channel.sv
// Single-satellite GPS L1 C/A baseband generator: carrier and code NCOs, G1/G2
// Gold-code LFSRs for PRN 1-37, 50 bps nav-bit modulation and signed I/Q output.
module gps_sat_channel #(
    parameter int PHASE_W = 32,
    parameter int GAIN_W  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   cfg_load,
    input  logic [PHASE_W-1:0]     freq,
    input  logic [PHASE_W-1:0]     code_rate,
    input  logic [GAIN_W-1:0]      gain,
    input  logic [5:0]             ca_sel,
    gps_sat_channel_if.slave       nav,
    output logic signed [GAIN_W:0] i_out,
    output logic signed [GAIN_W:0] q_out,
    output logic                   epoch,
    output logic                   bit_edge,
    output logic                   underrun,
    output logic                   cfg_err
);

    // Active configuration
    logic [PHASE_W-1:0] freq_r;
    logic [PHASE_W-1:0] code_rate_r;
    logic [GAIN_W-1:0]  gain_r;
    logic [5:0]         ca_sel_r;

    // NCOs, code generator and counters
    logic [PHASE_W-1:0] carr_phase;
    logic [PHASE_W-1:0] code_phase;
    logic [9:0]         g1;          // bit n holds LFSR stage n+1
    logic [9:0]         g2;
    logic [9:0]         chip_cnt;    // 0..1022
    logic [4:0]         ms_cnt;      // 0..19

    // Nav-bit path
    logic staging_full;
    logic staging_bit;
    logic active_bit;
    logic ready_en;                  // keeps data_ready low for the first cycle after reset

    // Combinational helpers
    logic [PHASE_W:0]       code_sum;
    logic                   code_carry;
    logic                   chip_wrap;
    logic                   ms_wrap;
    logic                   xfer;
    logic [9:0]             tap_mask;
    logic [9:0]             g1_next;
    logic [9:0]             g2_next;
    logic                   chip;
    logic                   neg_i;
    logic                   neg_q;
    logic signed [GAIN_W:0] mag;

    // Mask selecting the two G2 stages (numbered 1..10) of a PRN's tap pair.
    function automatic logic [9:0] mask2(input int a, input int b);
        return (10'd1 << (a - 1)) | (10'd1 << (b - 1));
    endfunction

    // G2 tap pair per PRN; SV37 reuses SV34's taps, out-of-range selects give no taps.
    always_comb begin
        tap_mask = 10'd0;
        case (ca_sel_r)
            6'd0:  tap_mask = mask2(2, 6);
            6'd1:  tap_mask = mask2(3, 7);
            6'd2:  tap_mask = mask2(4, 8);
            6'd3:  tap_mask = mask2(5, 9);
            6'd4:  tap_mask = mask2(1, 9);
            6'd5:  tap_mask = mask2(2, 10);
            6'd6:  tap_mask = mask2(1, 8);
            6'd7:  tap_mask = mask2(2, 9);
            6'd8:  tap_mask = mask2(3, 10);
            6'd9:  tap_mask = mask2(2, 3);
            6'd10: tap_mask = mask2(3, 4);
            6'd11: tap_mask = mask2(5, 6);
            6'd12: tap_mask = mask2(6, 7);
            6'd13: tap_mask = mask2(7, 8);
            6'd14: tap_mask = mask2(8, 9);
            6'd15: tap_mask = mask2(9, 10);
            6'd16: tap_mask = mask2(1, 4);
            6'd17: tap_mask = mask2(2, 5);
            6'd18: tap_mask = mask2(3, 6);
            6'd19: tap_mask = mask2(4, 7);
            6'd20: tap_mask = mask2(5, 8);
            6'd21: tap_mask = mask2(6, 9);
            6'd22: tap_mask = mask2(1, 3);
            6'd23: tap_mask = mask2(4, 6);
            6'd24: tap_mask = mask2(5, 7);
            6'd25: tap_mask = mask2(6, 8);
            6'd26: tap_mask = mask2(7, 9);
            6'd27: tap_mask = mask2(8, 10);
            6'd28: tap_mask = mask2(1, 6);
            6'd29: tap_mask = mask2(2, 7);
            6'd30: tap_mask = mask2(3, 8);
            6'd31: tap_mask = mask2(4, 9);
            6'd32: tap_mask = mask2(5, 10);
            6'd33: tap_mask = mask2(4, 10);
            6'd34: tap_mask = mask2(1, 7);
            6'd35: tap_mask = mask2(2, 8);
            6'd36: tap_mask = mask2(4, 10);
            default: tap_mask = 10'd0;
        endcase
    end

    // Code NCO carry, wrap detection, LFSR next state, symbol/carrier signs and handshake.
    always_comb begin
        code_sum   = {1'b0, code_phase} + {1'b0, code_rate_r};
        code_carry = code_sum[PHASE_W];
        chip_wrap  = code_carry && (chip_cnt == 10'd1022);
        ms_wrap    = chip_wrap && (ms_cnt == 5'd19);
        g1_next    = {g1[8:0], g1[2] ^ g1[9]};
        g2_next    = {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
        chip       = g1[9] ^ (^(g2 & tap_mask));
        // Negative when an odd number of (symbol, carrier) factors are -1.
        neg_i      = chip ^ active_bit ^ carr_phase[PHASE_W-1] ^ carr_phase[PHASE_W-2];
        neg_q      = chip ^ active_bit ^ carr_phase[PHASE_W-1];
        mag        = signed'({1'b0, gain_r});
        nav.data_ready = rst_n && ready_en && !staging_full && !cfg_load;
        xfer       = nav.data_valid && nav.data_ready;
    end

    // Atomic configuration load and registered PRN range flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            freq_r      <= '0;
            code_rate_r <= '0;
            gain_r      <= '0;
            ca_sel_r    <= '0;
            cfg_err     <= 1'b0;
        end else if (cfg_load) begin
            freq_r      <= freq;
            code_rate_r <= code_rate;
            gain_r      <= gain;
            ca_sel_r    <= ca_sel;
            cfg_err     <= (ca_sel > 6'd36);
        end
    end

    // Carrier/code NCOs, Gold-code LFSRs, chip and millisecond counters, epoch pulses.
    always_ff @(posedge clk) begin
        if (!rst_n || cfg_load) begin
            carr_phase <= '0;
            code_phase <= '0;
            chip_cnt   <= 10'd0;
            ms_cnt     <= 5'd0;
            g1         <= 10'h3FF;
            g2         <= 10'h3FF;
            epoch      <= 1'b0;
            bit_edge   <= 1'b0;
        end else begin
            epoch    <= enable && chip_wrap;
            bit_edge <= enable && ms_wrap;
            if (enable) begin
                carr_phase <= carr_phase + freq_r;
                code_phase <= code_sum[PHASE_W-1:0];
                if (chip_wrap) begin
                    chip_cnt <= 10'd0;
                    g1       <= 10'h3FF;
                    g2       <= 10'h3FF;
                    ms_cnt   <= ms_wrap ? 5'd0 : ms_cnt + 5'd1;
                end else if (code_carry) begin
                    chip_cnt <= chip_cnt + 10'd1;
                    g1       <= g1_next;
                    g2       <= g2_next;
                end
            end
        end
    end

    // Nav-bit staging register, bit-boundary handover and sticky underrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            staging_full <= 1'b0;
            staging_bit  <= 1'b0;
            active_bit   <= 1'b0;
            underrun     <= 1'b0;
            ready_en     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (cfg_load) begin
                staging_full <= 1'b0;
                active_bit   <= 1'b0;
                underrun     <= 1'b0;
            end else begin
                if (enable && ms_wrap) begin
                    if (staging_full) begin
                        active_bit <= staging_bit;
                    end else begin
                        active_bit <= 1'b0;
                        underrun   <= 1'b1;
                    end
                    // A bit offered on the boundary refills the register just emptied.
                    staging_full <= xfer;
                end else if (xfer) begin
                    staging_full <= 1'b1;
                end
                if (xfer) begin
                    staging_bit <= nav.data_bit;
                end
            end
        end
    end

    // Registered I/Q from the current chip, nav bit and carrier quadrant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_out <= '0;
            q_out <= '0;
        end else if (enable && !cfg_err) begin
            i_out <= neg_i ? -mag : mag;
            q_out <= neg_q ? -mag : mag;
        end else begin
            i_out <= '0;
            q_out <= '0;
        end
    end

endmodule

// File: tb/tb_gps_sat_channel.sv
// Self-checking bench for gps_sat_channel: directed scenarios plus randomized traffic,
// all compared against a sequence-level behavioural model.
`timescale 1ns/1ps
module tb_gps_sat_channel;
  localparam int PHASE_W = 32;
  localparam int GAIN_W  = 15;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] freq = '0;
  logic [31:0] code_rate = '0;
  logic [14:0] gain = '0;
  logic [5:0]  ca_sel = '0;
  logic [15:0] i_out;
  logic [15:0] q_out;
  logic        epoch;
  logic        bit_edge;
  logic        underrun;
  logic        cfg_err;

  gps_sat_channel_if nav();

  gps_sat_channel #(.PHASE_W(PHASE_W), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load),
    .freq(freq), .code_rate(code_rate), .gain(gain), .ca_sel(ca_sel),
    .nav(nav), .i_out(i_out), .q_out(q_out), .epoch(epoch),
    .bit_edge(bit_edge), .underrun(underrun), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Gold-code chips from the LFSR output recurrences: x[m] for m<0 is the all-ones preload,
  // stage k at chip n holds x[n-k]; arrays are indexed by m+10.
  bit g1x[0:1032];
  bit g2x[0:1032];
  int tap_a[37] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4,5,4,1,2,4};
  int tap_b[37] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9,10,10,7,8,10};

  function automatic void build_seqs();
    for (int j = 0; j < 10; j++) begin
      g1x[j] = 1'b1;
      g2x[j] = 1'b1;
    end
    for (int j = 10; j < 1033; j++) begin
      g1x[j] = g1x[j-3] ^ g1x[j-10];
      g2x[j] = g2x[j-2] ^ g2x[j-3] ^ g2x[j-6] ^ g2x[j-8] ^ g2x[j-9] ^ g2x[j-10];
    end
  endfunction

  function automatic bit chip_of(input int sel, input int k);
    if (sel > 36) return 1'b0;
    return g1x[k] ^ g2x[k + 10 - tap_a[sel]] ^ g2x[k + 10 - tap_b[sel]];
  endfunction

  function automatic logic [15:0] amp(input bit neg, input int g);
    logic [15:0] v;
    v = neg ? 16'(0 - g) : 16'(g);
    return v;
  endfunction

  logic [31:0] m_carr, m_code, m_freq, m_rate;
  int          m_gain, m_sel, m_k, m_ms;
  bit          m_err, m_active, m_underrun, m_ready_en;
  bit          m_stage[$];
  logic [35:0] exp_q[$];   // {i, q, epoch, bit_edge, underrun, cfg_err}

  function automatic bit exp_ready();
    return rst_n && m_ready_en && (m_stage.size() == 0) && !cfg_load;
  endfunction

  task automatic model_step();
    logic [15:0] ei, eq;
    bit ee, eb, c, rdy, xfer, carry;
    longint sum;
    ei = '0; eq = '0; ee = 1'b0; eb = 1'b0;
    if (!rst_n) begin
      m_carr = '0; m_code = '0; m_freq = '0; m_rate = '0;
      m_gain = 0; m_sel = 0; m_k = 0; m_ms = 0;
      m_err = 0; m_active = 0; m_underrun = 0; m_ready_en = 0;
      m_stage.delete();
    end else begin
      if (enable && !m_err) begin
        c  = chip_of(m_sel, m_k);
        ei = amp(c ^ m_active ^ m_carr[31] ^ m_carr[30], m_gain);
        eq = amp(c ^ m_active ^ m_carr[31], m_gain);
      end
      rdy = exp_ready();
      if (cfg_load) begin
        m_freq = freq; m_rate = code_rate; m_gain = int'(gain); m_sel = int'(ca_sel);
        m_err = (ca_sel > 36);
        m_carr = '0; m_code = '0; m_k = 0; m_ms = 0;
        m_stage.delete(); m_underrun = 0; m_active = 0;
      end else begin
        xfer = nav.data_valid && rdy;
        if (enable) begin
          sum   = longint'(m_code) + longint'(m_rate);
          carry = (sum >= 64'h1_0000_0000);
          m_code = 32'(sum);
          m_carr = m_carr + m_freq;
          if (carry) begin
            if (m_k == 1022) begin
              m_k = 0;
              ee = 1'b1;
              if (m_ms == 19) begin
                m_ms = 0;
                eb = 1'b1;
              end else begin
                m_ms++;
              end
            end else begin
              m_k++;
            end
          end
        end
        if (eb) begin
          if (m_stage.size() != 0) m_active = m_stage.pop_front();
          else begin
            m_active = 1'b0;
            m_underrun = 1'b1;
          end
        end
        if (xfer) m_stage.push_back(nav.data_bit);
      end
      m_ready_en = 1'b1;
    end
    exp_q.push_back({ei, eq, ee, eb, m_underrun, m_err});
  endtask

  // ---------------- driver: one clock cycle, checked against the model ----------------
  task automatic cycle();
    logic [35:0] e;
    #2;
    check("data_ready", nav.data_ready, exp_ready());
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("i_out", i_out, e[35:20]);
    check("q_out", q_out, e[19:4]);
    check("epoch", epoch, e[3]);
    check("bit_edge", bit_edge, e[2]);
    check("underrun", underrun, e[1]);
    check("cfg_err", cfg_err, e[0]);
  endtask

  task automatic load_cfg(input logic [31:0] f, input logic [31:0] r, input int g, input int s);
    freq = f; code_rate = r; gain = 15'(g); ca_sel = 6'(s);
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
  endtask

  task automatic wait_pulse(input bit want_bit_edge, input int max_cyc, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(want_bit_edge ? bit_edge : epoch) && n < max_cyc);
    if (!(want_bit_edge ? bit_edge : epoch)) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_pulse: no pulse within %0d cycles", max_cyc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [9:0] pat;
    bit nq_i[4] = '{1, 0, 0, 1};
    bit nq_q[4] = '{1, 1, 0, 0};
    nav.data_valid = 1'b0;
    nav.data_bit   = 1'b0;
    build_seqs();

    // Reset state
    rst_n = 1'b0;
    repeat (3) cycle();
    check("rst_i", i_out, 16'd0);
    check("rst_ready", nav.data_ready, 1'b0);
    rst_n = 1'b1;
    cycle();
    cycle();

    // PRN1 chip sequence, 2 cycles per chip, q follows i with freq=0
    enable = 1'b1;
    load_cfg(32'h0, 32'h8000_0000, 1000, 0);
    pat = 10'b1100100000;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      check("prn1_i", i_out, amp(pat[9 - (c - 1) / 2], 1000));
      check("prn1_q", q_out, amp(pat[9 - (c - 1) / 2], 1000));
    end
    wait_pulse(0, 2100, n);
    check("prn1_epoch1", n + 20, 2046);
    wait_pulse(0, 2100, n);
    check("prn1_epoch2", n, 2046);

    // Carrier quadrants with the code frozen on chip 0 (chip=1, s=-1)
    load_cfg(32'h4000_0000, 32'h0, 5, 0);
    for (int c = 1; c <= 8; c++) begin
      cycle();
      check("carr_i", i_out, amp(nq_i[(c - 1) % 4], 5));
      check("carr_q", q_out, amp(nq_q[(c - 1) % 4], 5));
    end

    // Nav data: one bit, then withheld
    load_cfg(32'h0, 32'hFFFF_FFFF, 700, 4);
    nav.data_valid = 1'b1;
    nav.data_bit   = 1'b1;
    cycle();
    nav.data_valid = 1'b0;
    nav.data_bit   = 1'b0;
    wait_pulse(1, 21000, n);
    check("nav_edge1", n + 1, 20461);
    check("nav_ready", nav.data_ready, 1'b1);
    cycle();
    check("nav_inverted", i_out, amp(1'b0, 700));
    wait_pulse(1, 21000, n);
    check("nav_edge2", n + 1, 20460);
    check("nav_underrun", underrun, 1'b1);

    // cfg_load in the bit_edge cycle with a bit offered
    cfg_load = 1'b1;
    nav.data_valid = 1'b1;
    nav.data_bit   = 1'b1;
    #1;
    check("sim_ready", nav.data_ready, 1'b0);
    cycle();
    cfg_load = 1'b0;
    nav.data_valid = 1'b0;
    check("underrun_bit0", i_out, amp(1'b1, 700));
    check("sim_underrun", underrun, 1'b0);
    #1;
    check("sim_staging_empty", nav.data_ready, 1'b1);
    wait_pulse(0, 1100, n);
    check("sim_epoch", n, 1024);

    // PRN 37 uses SV34 taps
    load_cfg(32'h0, 32'h8000_0000, 321, 36);
    for (int c = 1; c <= 60; c++) begin
      cycle();
      check("prn37_i", i_out, amp(chip_of(33, (c - 1) / 2), 321));
    end
    load_cfg(32'h0, 32'h8000_0000, 321, 33);
    repeat (60) cycle();

    // Out-of-range PRN: outputs muted, counters still run
    load_cfg(32'h1234_5678, 32'h8000_0000, 1234, 40);
    check("err_flag", cfg_err, 1'b1);
    wait_pulse(0, 2100, n);
    check("err_epoch1", n, 2046);
    check("err_i", i_out, 16'd0);
    wait_pulse(0, 2100, n);
    check("err_epoch2", n, 2046);

    // enable dropped mid-epoch, handshake still live
    load_cfg(32'h0765_4321, 32'h8000_0000, 3000, 7);
    repeat (500) cycle();
    enable = 1'b0;
    for (int c = 0; c < 100; c++) begin
      nav.data_valid = ($urandom_range(0, 3) == 0);
      nav.data_bit   = 1'($urandom_range(0, 1));
      cycle();
      check("en_low_i", i_out, 16'd0);
    end
    nav.data_valid = 1'b0;
    enable = 1'b1;
    repeat (300) cycle();

    // One-cycle reset mid-bit
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("mid_rst_i", i_out, 16'd0);
    check("mid_rst_q", q_out, 16'd0);
    check("mid_rst_epoch", epoch, 1'b0);
    #1;
    check("mid_rst_ready0", nav.data_ready, 1'b0);
    cycle();
    check("mid_rst_ready1", nav.data_ready, 1'b1);

    // Randomized traffic
    for (int s = 0; s < 3; s++) begin
      load_cfg($urandom, (s == 0) ? $urandom_range(32'hC000_0000, 32'hFFFF_FFFF) : $urandom,
               int'($urandom_range(0, 32767)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(37, 63)) : int'($urandom_range(0, 36)));
      for (int c = 0; c < 3000; c++) begin
        enable         = ($urandom_range(0, 9) != 0);
        nav.data_valid = ($urandom_range(0, 2) == 0);
        nav.data_bit   = 1'($urandom_range(0, 1));
        cfg_load       = ($urandom_range(0, 999) == 0);
        cycle();
      end
      cfg_load = 1'b0;
      nav.data_valid = 1'b0;
      enable = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
